data_cache_wt: RTL

//  Direct-mapped, write-through, no-write-allocate data cache between the

---
 rtl/data_cache_wt_if.sv | 43 ++++
 rtl/data_cache_wt.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/data_cache_wt_if.sv
// +-------------------------------------------------------------------------+
// | Module  : data_cache_wt_if                                              |
// | Purpose : CPU load/store port and word-wide memory port of the cache    |
// | Rev     : 1.0  initial release                                          |
// +-------------------------------------------------------------------------+
`default_nettype none

interface data_cache_wt_if #(
  parameter int WIDTH = 32
);
  logic             cpu_req;
  logic             cpu_we;
  logic [2:0]       cpu_mode;
  logic [WIDTH-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic             cpu_ready;
  logic [WIDTH-1:0] cpu_rdata;

  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_wstrb;
  logic             mem_ack;
  logic [WIDTH-1:0] mem_rdata;

  // Environment view: pipeline on one side, data_memory on the other.
  modport master (
    output cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/data_cache_wt.sv
// +-------------------------------------------------------------------------+
// | Module  : data_cache_wt                                                 |
// | Purpose : Direct-mapped write-through, no-write-allocate data cache     |
// | Rev     : 1.0  initial release                                          |
// +-------------------------------------------------------------------------+
`default_nettype none

module data_cache_wt #(
  parameter int WIDTH = 32,
  parameter int SETS  = 64
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  data_cache_wt_if.slave   bus,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = WIDTH - 2 - IDX;

  localparam logic [2:0] MODE_W  = 3'b001;
  localparam logic [2:0] MODE_H  = 3'b010;
  localparam logic [2:0] MODE_B  = 3'b011;
  localparam logic [2:0] MODE_HU = 3'b100;
  localparam logic [2:0] MODE_BU = 3'b101;

  localparam logic [WIDTH-1:0] WORD_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [SETS-1:0]  valid;
  logic [TAGW-1:0]  tag_mem  [SETS];
  logic [WIDTH-1:0] data_mem [SETS];
  logic [2:0]       req_mode;

  logic [IDX-1:0]   cpu_idx, line_idx;
  logic [TAGW-1:0]  cpu_tag, line_tag;
  logic             mode_ok, cpu_hit, line_hit;
  logic             do_hit, do_miss, do_store, do_invalid, fill_done, write_done;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] m);
    case (m)
      MODE_W:  extract = w;
      MODE_H:  extract = {{16{w[31]}}, w[31:16]};
      MODE_HU: extract = {16'h0, w[31:16]};
      MODE_B:  extract = {{24{w[31]}}, w[31:24]};
      MODE_BU: extract = {24'h0, w[31:24]};
      default: extract = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] strb);
    merge = old;
    for (int j = 0; j < 4; j++)
      if (strb[j]) merge[8*j +: 8] = wd[8*j +: 8];
  endfunction

  // The in-flight access is identified by the registered mem_addr, so a
  // fill or write-hit updates the line that was actually sent to memory.
  assign cpu_idx  = bus.cpu_addr[2+IDX-1:2];
  assign cpu_tag  = bus.cpu_addr[WIDTH-1:2+IDX];
  assign line_idx = bus.mem_addr[2+IDX-1:2];
  assign line_tag = bus.mem_addr[WIDTH-1:2+IDX];
  assign mode_ok  = (bus.cpu_mode >= MODE_W) && (bus.cpu_mode <= MODE_BU);
  assign cpu_hit  = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  assign line_hit = valid[line_idx] && (tag_mem[line_idx] == line_tag);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_hit     = 1'b0;
    do_miss    = 1'b0;
    do_store   = 1'b0;
    do_invalid = 1'b0;
    fill_done  = 1'b0;
    write_done = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          if (!mode_ok) begin
            do_invalid = 1'b1;
            state_next = RESP;
          end else if (bus.cpu_we) begin
            do_store   = 1'b1;
            state_next = WRITE;
          end else if (cpu_hit) begin
            do_hit     = 1'b1;
            state_next = RESP;
          end else begin
            do_miss    = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          fill_done  = 1'b1;
          state_next = RESP;
        end
      end
      WRITE: begin
        if (bus.mem_ack) begin
          write_done = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid         <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      req_mode      <= '0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
    end else begin
      bus.cpu_ready <= (state_next == RESP);
      if (do_invalid) bus.cpu_rdata <= '0;
      if (do_hit) begin
        bus.cpu_rdata <= extract(data_mem[cpu_idx], bus.cpu_mode);
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end
      if (do_miss) begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        req_mode      <= bus.cpu_mode;
        bus.mem_req   <= 1'b1;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= bus.cpu_addr & WORD_MASK;
        bus.mem_wdata <= '0;
        bus.mem_wstrb <= 4'b0000;
      end
      if (do_store) begin
        bus.mem_req  <= 1'b1;
        bus.mem_we   <= 1'b1;
        bus.mem_addr <= bus.cpu_addr & WORD_MASK;
        case (bus.cpu_mode)
          MODE_W: begin
            bus.mem_wstrb <= 4'b1111;
            bus.mem_wdata <= bus.cpu_wdata;
          end
          MODE_H, MODE_HU: begin
            bus.mem_wstrb <= 4'b1100;
            bus.mem_wdata <= {bus.cpu_wdata[15:0], 16'h0};
          end
          default: begin
            bus.mem_wstrb <= 4'b1000;
            bus.mem_wdata <= {bus.cpu_wdata[7:0], 24'h0};
          end
        endcase
      end
      if (fill_done) begin
        bus.mem_req     <= 1'b0;
        valid[line_idx] <= 1'b1;
        bus.cpu_rdata   <= extract(bus.mem_rdata, req_mode);
      end
      if (write_done) begin
        bus.mem_req   <= 1'b0;
        bus.cpu_rdata <= '0;
      end
    end
  end

  // Tag/data arrays need no reset: the valid bits gate every lookup.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (fill_done) begin
        tag_mem[line_idx]  <= line_tag;
        data_mem[line_idx] <= bus.mem_rdata;
      end
      if (write_done && line_hit)
        data_mem[line_idx] <= merge(data_mem[line_idx], bus.mem_wdata, bus.mem_wstrb);
    end
  end

endmodule

`default_nettype wire
